// File: rtl/sub_stage_ctrl.sv
// Sequencing controller for an external 4-bit subtractor: latches one operand pair,
// waits SETTLE_CYCLES (legal 1..15) for the result, then holds it until the consumer takes it.
module sub_stage_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] sub_a,
    output logic [3:0] sub_b,
    input  logic [3:0] sub_s,
    input  logic       sub_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_diff,
    output logic       out_neg,
    output logic [3:0] out_mag,
    output logic       out_zero,
    output logic       out_mismatch,
    output logic [7:0] op_count,
    output logic [7:0] err_count
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;

    logic       in_fire;
    logic       capture;
    logic       out_fire;

    logic [3:0] ref_diff;
    logic       ref_cout;
    logic       ref_bad;
    logic [3:0] cap_mag;

    assign in_fire  = in_valid && in_ready;
    // A count of 0 can only come from an out-of-range parameter; treat it as 1 so the FSM never stalls.
    assign capture  = (state == SETTLE) && (settle_cnt <= 4'd1);
    assign out_fire = (state == HOLD) && out_valid && out_ready;

    // Independent reference for the external subtractor, evaluated on the held operands.
    assign ref_diff = sub_a - sub_b;
    assign ref_cout = (sub_a >= sub_b);
    assign ref_bad  = (sub_s != ref_diff) || (sub_cout != ref_cout);
    assign cap_mag  = sub_cout ? sub_s : (~sub_s + 4'd1);

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_fire)  state_next = SETTLE;
            SETTLE:  if (capture)  state_next = HOLD;
            HOLD:    if (out_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: reset is synchronous; all datapath registers are cleared so outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            settle_cnt   <= 4'd0;
            sub_a        <= 4'd0;
            sub_b        <= 4'd0;
            out_valid    <= 1'b0;
            out_diff     <= 4'd0;
            out_neg      <= 1'b0;
            out_mag      <= 4'd0;
            out_zero     <= 1'b0;
            out_mismatch <= 1'b0;
            op_count     <= 8'd0;
            err_count    <= 8'd0;
        end else begin
            state    <= state_next;
            // Registered so it stays low through reset and rises one cycle after HOLD exits.
            in_ready <= (state_next == IDLE);

            if (in_fire) begin
                sub_a      <= in_a;
                sub_b      <= in_b;
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (capture) begin
                out_valid    <= 1'b1;
                out_diff     <= sub_s;
                out_neg      <= ~sub_cout;
                out_mag      <= cap_mag;
                out_zero     <= (sub_s == 4'd0);
                out_mismatch <= ref_bad;
                if (ref_bad && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end

            if (out_fire) begin
                out_valid <= 1'b0;
                op_count  <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sub_stage_ctrl.sv
// Scoreboard bench for sub_stage_ctrl: three instances (SETTLE_CYCLES 1, 4, 15), each with
// a behavioural subtractor that can be forced faulty.
module tb_sub_stage_ctrl;

    localparam int N = 3;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] diff;
        logic [3:0] mag;
        logic       neg;
        logic       zero;
        logic       mis;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n     [N];
    logic       in_valid  [N];
    logic [3:0] in_a      [N];
    logic [3:0] in_b      [N];
    logic       out_ready [N];
    logic       fault     [N];

    wire        in_ready     [N];
    wire [3:0]  sub_a        [N];
    wire [3:0]  sub_b        [N];
    wire [3:0]  sub_s        [N];
    wire        sub_cout     [N];
    wire        out_valid    [N];
    wire [3:0]  out_diff     [N];
    wire        out_neg      [N];
    wire [3:0]  out_mag      [N];
    wire        out_zero     [N];
    wire        out_mismatch [N];
    wire [7:0]  op_count     [N];
    wire [7:0]  err_count    [N];

    int   checks = 0;
    int   errors = 0;
    int   exp_op  [N];
    int   exp_err [N];
    exp_t sb[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign sub_s[g]    = fault[g] ? 4'd0 : 4'(sub_a[g] - sub_b[g]);
        assign sub_cout[g] = (sub_a[g] >= sub_b[g]);

        sub_stage_ctrl #(
            .SETTLE_CYCLES(g == 0 ? 1 : (g == 1 ? 4 : 15))
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n[g]),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .in_a        (in_a[g]),
            .in_b        (in_b[g]),
            .sub_a       (sub_a[g]),
            .sub_b       (sub_b[g]),
            .sub_s       (sub_s[g]),
            .sub_cout    (sub_cout[g]),
            .out_valid   (out_valid[g]),
            .out_ready   (out_ready[g]),
            .out_diff    (out_diff[g]),
            .out_neg     (out_neg[g]),
            .out_mag     (out_mag[g]),
            .out_zero    (out_zero[g]),
            .out_mismatch(out_mismatch[g]),
            .op_count    (op_count[g]),
            .err_count   (err_count[g])
        );
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int settle_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 4 : 15);
    endfunction

    task automatic check_zeroed(input int idx, input string tag);
        check({tag, "_out_valid"}, out_valid[idx], 0);
        check({tag, "_sub_a"}, sub_a[idx], 0);
        check({tag, "_sub_b"}, sub_b[idx], 0);
        check({tag, "_out_diff"}, out_diff[idx], 0);
        check({tag, "_out_mag"}, out_mag[idx], 0);
        check({tag, "_out_neg"}, out_neg[idx], 0);
        check({tag, "_out_zero"}, out_zero[idx], 0);
        check({tag, "_out_mismatch"}, out_mismatch[idx], 0);
        check({tag, "_op_count"}, op_count[idx], 0);
        check({tag, "_err_count"}, err_count[idx], 0);
    endtask

    // One full transaction; hold > 0 keeps out_ready low (and in_valid high) for that many HOLD cycles.
    task automatic do_op(input int idx, input logic [3:0] a, input logic [3:0] b, input int hold);
        exp_t e;
        int   n;
        e.a    = a;
        e.b    = b;
        e.neg  = (a < b);
        if (fault[idx]) begin
            e.diff = 4'd0;
            e.mag  = 4'd0;
        end else begin
            e.diff = 4'(a - b);
            e.mag  = e.neg ? 4'(b - a) : 4'(a - b);
        end
        e.zero = (e.diff == 4'd0);
        e.mis  = fault[idx] && (a != b);

        @(negedge clk);
        in_a[idx]      = a;
        in_b[idx]      = b;
        in_valid[idx]  = 1'b1;
        out_ready[idx] = (hold == 0);
        n = 0;
        while (!in_ready[idx] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", in_ready[idx], 1);
        sb.push_back(e);

        @(negedge clk);
        in_valid[idx] = (hold > 0);
        in_a[idx]     = 4'($urandom_range(0, 15));
        in_b[idx]     = 4'($urandom_range(0, 15));
        n = 1;
        while (!out_valid[idx] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n - 1, settle_of(idx));

        e = sb.pop_front();
        if (e.mis && exp_err[idx] < 255) exp_err[idx]++;
        check("out_diff", out_diff[idx], e.diff);
        check("out_neg", out_neg[idx], e.neg);
        check("out_mag", out_mag[idx], e.mag);
        check("out_zero", out_zero[idx], e.zero);
        check("out_mismatch", out_mismatch[idx], e.mis);
        check("err_count", err_count[idx], exp_err[idx]);
        check("sub_a_held", sub_a[idx], e.a);
        check("sub_b_held", sub_b[idx], e.b);
        check("in_ready_busy", in_ready[idx], 0);
        check("op_count_pre", op_count[idx], exp_op[idx]);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid[idx], 1);
            check("bp_out_diff", out_diff[idx], e.diff);
            check("bp_out_mag", out_mag[idx], e.mag);
            check("bp_out_neg", out_neg[idx], e.neg);
            check("bp_in_ready", in_ready[idx], 0);
            check("bp_op_count", op_count[idx], exp_op[idx]);
        end
        in_valid[idx]  = 1'b0;
        out_ready[idx] = 1'b1;

        @(negedge clk);
        exp_op[idx] = (exp_op[idx] + 1) % 256;
        check("post_out_valid", out_valid[idx], 0);
        check("post_op_count", op_count[idx], exp_op[idx]);
        check("post_in_ready", in_ready[idx], 1);
        check("post_out_diff", out_diff[idx], e.diff);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        logic [3:0] pa [4];
        logic [3:0] pb [4];
        logic [3:0] ra;
        logic [3:0] rb;
        pa = '{4'h3, 4'h5, 4'hF, 4'h0};
        pb = '{4'h3, 4'hB, 4'hD, 4'h8};

        for (int i = 0; i < N; i++) begin
            rst_n[i]     = 1'b0;
            in_valid[i]  = 1'b0;
            in_a[i]      = 4'd0;
            in_b[i]      = 4'd0;
            out_ready[i] = 1'b0;
            fault[i]     = 1'b0;
            exp_op[i]    = 0;
            exp_err[i]   = 0;
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_in_ready", in_ready[i], 0);
            check_zeroed(i, "rst");
        end
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) check("first_in_ready", in_ready[i], 1);

        // Basic, table, backpressure, then faulty subtractor with saturation and op_count wrap.
        do_op(0, 4'h1, 4'h3, 0);
        for (int i = 0; i < 4; i++) do_op(0, pa[i], pb[i], 0);
        check("op_count_table", op_count[0], 5);
        do_op(0, 4'h7, 4'h2, 5);
        fault[0] = 1'b1;
        do_op(0, 4'h9, 4'h3, 0);
        check("err_count_first", err_count[0], 1);
        for (int i = 0; i < 299; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'(ra + 4'($urandom_range(1, 15)));
            do_op(0, ra, rb, 0);
        end
        check("err_count_sat", err_count[0], 255);
        fault[0] = 1'b0;
        do_op(0, 4'hC, 4'h4, 0);

        // Reset pulse in the middle of a 4-cycle settle.
        do_op(1, 4'h6, 4'h2, 0);
        @(negedge clk);
        in_a[1]     = 4'hC;
        in_b[1]     = 4'h5;
        in_valid[1] = 1'b1;
        @(negedge clk);
        check("rst_mid_accept", in_ready[1], 0);
        in_valid[1] = 1'b0;
        rst_n[1]    = 1'b0;
        @(negedge clk);
        rst_n[1]   = 1'b1;
        exp_op[1]  = 0;
        exp_err[1] = 0;
        check("rst_mid_in_ready", in_ready[1], 0);
        check_zeroed(1, "rst_mid");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_mid_no_valid", out_valid[1], 0);
            check("rst_mid_idle_ready", in_ready[1], 1);
        end
        do_op(1, 4'hC, 4'h5, 0);
        do_op(1, 4'h2, 4'hA, 2);

        // Longest settle.
        do_op(2, 4'h2, 4'h9, 0);
        do_op(2, 4'hE, 4'h6, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_stage_ctrl.md
SUB_STAGE_CTRL -- requirements
Module: sub_stage_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles the operands are held on sub_a/sub_b before the result is captured; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, operand pair offered.
REQ-005 SHALL have port in_ready, output, 1, block accepts an operand pair.
REQ-006 SHALL have ports in_a and in_b, input, 4 each, minuend and subtrahend.
REQ-007 SHALL have ports sub_a and sub_b, output, 4 each, registered operands driven into the 4-bit subtractor.
REQ-008 SHALL have port sub_s, input, 4, subtractor difference.
REQ-009 SHALL have port sub_cout, input, 1, subtractor carry-out, where 1 means no borrow (a>=b).
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port out_diff, output, 4, captured sub_s.
REQ-013 SHALL have port out_neg, output, 1, equal to NOT captured sub_cout.
REQ-014 SHALL have port out_mag, output, 4, magnitude of the difference.
REQ-015 SHALL have port out_zero, output, 1, high when out_diff==0.
REQ-016 SHALL have port out_mismatch, output, 1, captured result disagrees with the internal reference.
REQ-017 SHALL have port op_count, output, 8, completed output handshakes.
REQ-018 SHALL have port err_count, output, 8, mismatching results.

Function
REQ-019 SHALL implement FSM IDLE -> SETTLE -> HOLD -> IDLE.
REQ-020 SHALL assert in_ready only in IDLE; in_valid && in_ready at an edge latches in_a/in_b into sub_a/sub_b, loads the settle counter with SETTLE_CYCLES, and moves to SETTLE.
REQ-021 SHALL hold sub_a/sub_b stable from the accept edge until the next accept; in_a/in_b changes outside the handshake are ignored.
REQ-022 In SETTLE, SHALL decrement the counter each cycle; at the edge where the counter equals 1, it SHALL capture sub_s/sub_cout into the out_* registers, set out_valid and move to HOLD, giving acceptance-to-out_valid latency of exactly SETTLE_CYCLES cycles.
REQ-023 SHALL compute out_mag as out_diff when out_neg=0, and (~out_diff+1) mod 16 when out_neg=1; diff 0x8 with out_neg=1 gives out_mag=8.
REQ-024 SHALL compute reference r=(sub_a-sub_b) mod 16 and set out_mismatch at capture iff sub_s!=r or sub_cout!=(sub_a>=sub_b).
REQ-025 In HOLD, SHALL keep out_valid and all out_* stable until out_valid && out_ready at an edge, then clear out_valid, increment op_count (wrap 255->0) and return to IDLE.
REQ-026 SHALL increment err_count at the capture edge when out_mismatch is set, saturating at 255.
REQ-027 SHALL NOT accept a new pair in the same cycle as an output handshake: one transaction in flight, and in_ready rises the cycle after HOLD exits.
REQ-028 SHALL leave all outputs unchanged in IDLE except in_ready.
REQ-029 SHALL ignore out_ready outside HOLD.

Reset
REQ-030 While rst_n=0 at an edge, SHALL force state IDLE with in_ready=0, out_valid=0, sub_a=sub_b=0, out_diff=out_mag=0, out_neg=0, out_zero=0, out_mismatch=0, op_count=err_count=0, settle counter 0.
REQ-031 SHALL assert in_ready in the first cycle after the first edge with rst_n=1.
REQ-032 Reset asserted during SETTLE or HOLD SHALL abort the transaction with no capture and no count increment.

Verification
REQ-033 SHALL cover SETTLE_CYCLES=1, a=1, b=3, subtractor model attached -> out_valid one cycle after accept, diff=0xE, neg=1, mag=2, zero=0, mismatch=0.
REQ-034 SHALL cover pairs (3,3), (5,0xB), (0xF,0xD), (0,8) -> diff/neg/mag = 0/0/0 with zero=1; 0xA/1/6; 2/0/2; 8/1/8; op_count=4 after all handshakes.
REQ-035 SHALL cover backpressure: out_ready held low 5 cycles with in_valid high -> out_* stable, in_ready=0 throughout, single op_count increment on release.
REQ-036 SHALL cover a faulty model forcing sub_s=0 with a=9, b=3 -> out_mismatch=1, err_count=1; 300 faulty ops -> err_count=255.
REQ-037 SHALL cover rst_n low for one cycle during SETTLE (SETTLE_CYCLES=4) -> all outputs zero, no out_valid, op_count=0, next transaction correct.
REQ-038 SHALL cover SETTLE_CYCLES=15 -> out_valid exactly 15 cycles after accept.
